// File: rtl/roi_color_accumulator_pkg.sv
// Shared colour-statistics types: colour codes, accumulator FSM states, pixel classes, counters.
// Imported by the accumulator, the colour stabiliser and the game logic controller.
package dice_color_pkg;

  localparam int CNT_W = 15;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2,
    NONE  = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACCUM      = 2'd1,
    DECIDE     = 2'd2,
    PUBLISH    = 2'd3
  } acc_state_t;

  typedef enum logic [2:0] {
    PIX_RED   = 3'd0,
    PIX_GREEN = 3'd1,
    PIX_BLUE  = 3'd2,
    PIX_WHITE = 3'd3,
    PIX_OTHER = 3'd4
  } pix_class_t;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t red;
    cnt_t green;
    cnt_t blue;
    cnt_t white;
  } counts_t;

  // Saturating increment: a counter at all-ones stays there.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/roi_color_accumulator_if.sv
// Scan-side inputs (sync, coordinates, frame-buffer data) and per-frame result outputs.
// master = VGA syncher / frame buffer / stabiliser side, slave = accumulator.
interface roi_color_accumulator_if;
  import dice_color_pkg::*;

  logic        DE;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic [15:0] pixel_rgb;

  color_t      frame_color;
  logic        white_flag;
  logic        frame_valid;
  cnt_t        red_cnt;
  cnt_t        green_cnt;
  cnt_t        blue_cnt;
  cnt_t        white_cnt;

  modport master (
    output DE, x_pixel, y_pixel, pixel_rgb,
    input  frame_color, white_flag, frame_valid,
    input  red_cnt, green_cnt, blue_cnt, white_cnt
  );

  modport slave (
    input  DE, x_pixel, y_pixel, pixel_rgb,
    output frame_color, white_flag, frame_valid,
    output red_cnt, green_cnt, blue_cnt, white_cnt
  );

endinterface

// File: rtl/roi_color_accumulator_classifier.sv
// Combinational RGB565-to-class map (white > red > green > blue > other); zero latency, no flow control.
module pixel_classifier
  import dice_color_pkg::*;
#(
  parameter logic [3:0] TH_HI    = 4'd10,
  parameter logic [3:0] TH_LO    = 4'd6,
  parameter logic [3:0] WHITE_TH = 4'd12
) (
  input  logic [15:0] rgb,
  output pix_class_t  pix_class
);

  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       unused_lsbs;

  // Top four bits of each RGB565 channel; the remaining LSBs are noise for classification.
  assign r = rgb[15:12];
  assign g = rgb[10:7];
  assign b = rgb[4:1];
  assign unused_lsbs = ^{rgb[11], rgb[6:5], rgb[0]};

  always_comb begin
    pix_class = PIX_OTHER;
    if (r >= WHITE_TH && g >= WHITE_TH && b >= WHITE_TH) begin
      pix_class = PIX_WHITE;
    end else if (r >= TH_HI && g <= TH_LO && b <= TH_LO) begin
      pix_class = PIX_RED;
    end else if (g >= TH_HI && r <= TH_LO && b <= TH_LO) begin
      pix_class = PIX_GREEN;
    end else if (b >= TH_HI && r <= TH_LO && g <= TH_LO) begin
      pix_class = PIX_BLUE;
    end
  end

endmodule

// File: rtl/roi_color_accumulator.sv
// Per-frame ROI colour counter; results + frame_valid appear two cycles after the last ROI pixel is sampled.
// No backpressure: frame_valid is a one-cycle strobe the consumer must take when it fires.
module roi_color_accumulator
  import dice_color_pkg::*;
#(
  parameter logic [9:0] ROI_X_START = 10'd100,
  parameter logic [9:0] ROI_X_END   = 10'd220,
  parameter logic [9:0] ROI_Y_START = 10'd60,
  parameter logic [9:0] ROI_Y_END   = 10'd180,
  parameter logic [3:0] TH_HI       = 4'd10,
  parameter logic [3:0] TH_LO       = 4'd6,
  parameter logic [3:0] WHITE_TH    = 4'd12,
  parameter cnt_t       MIN_PIXELS  = 15'd1000
) (
  input  logic                    clk,
  input  logic                    reset,
  roi_color_accumulator_if.slave  bus
);

  logic       de_d;
  logic [9:0] x_d;
  logic [9:0] y_d;

  pix_class_t pix_class;
  logic       in_roi;
  logic       last_pix;
  logic       frame_start;

  acc_state_t state;
  acc_state_t state_nxt;
  logic       clr_cnt;
  logic       acc_en;
  logic       load_out;

  counts_t    cnt;
  cnt_t       max_cnt;
  color_t     win_color;
  color_t     dec_color;

  color_t     frame_color_q;
  logic       white_flag_q;
  logic       frame_valid_q;
  counts_t    cnt_out_q;

  // Coordinates are delayed one cycle to line up with the frame-buffer read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_d <= 1'b0;
      x_d  <= '0;
      y_d  <= '0;
    end else begin
      de_d <= bus.DE;
      x_d  <= bus.x_pixel;
      y_d  <= bus.y_pixel;
    end
  end

  pixel_classifier #(
    .TH_HI    (TH_HI),
    .TH_LO    (TH_LO),
    .WHITE_TH (WHITE_TH)
  ) u_classifier (
    .rgb       (bus.pixel_rgb),
    .pix_class (pix_class)
  );

  assign in_roi = de_d
               && (x_d >= ROI_X_START) && (x_d < ROI_X_END)
               && (y_d >= ROI_Y_START) && (y_d < ROI_Y_END);

  assign last_pix = in_roi
                 && (x_d == ROI_X_END - 10'd1)
                 && (y_d == ROI_Y_END - 10'd1);

  // Qualified by DE so the zeroed delay registers after reset cannot start a partial frame.
  assign frame_start = de_d && (y_d < ROI_Y_START);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_FRAME;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    acc_en    = 1'b0;
    load_out  = 1'b0;
    unique case (state)
      WAIT_FRAME: begin
        if (frame_start) begin
          clr_cnt   = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = in_roi;
        if (last_pix) begin
          state_nxt = DECIDE;
        end
      end
      DECIDE: begin
        load_out  = 1'b1;
        state_nxt = PUBLISH;
      end
      PUBLISH: begin
        state_nxt = WAIT_FRAME;
      end
      default: begin
        state_nxt = WAIT_FRAME;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (acc_en) begin
      case (pix_class)
        PIX_RED:   cnt.red   <= sat_inc(cnt.red);
        PIX_GREEN: cnt.green <= sat_inc(cnt.green);
        PIX_BLUE:  cnt.blue  <= sat_inc(cnt.blue);
        PIX_WHITE: cnt.white <= sat_inc(cnt.white);
        default:   ;
      endcase
    end
  end

  // Strictly-greater replacement keeps ties resolved red > green > blue.
  always_comb begin
    max_cnt   = cnt.red;
    win_color = RED;
    if (cnt.green > max_cnt) begin
      max_cnt   = cnt.green;
      win_color = GREEN;
    end
    if (cnt.blue > max_cnt) begin
      max_cnt   = cnt.blue;
      win_color = BLUE;
    end
    dec_color = (max_cnt >= MIN_PIXELS) ? win_color : NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_color_q <= NONE;
      white_flag_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      cnt_out_q     <= '0;
    end else begin
      frame_valid_q <= load_out;
      if (load_out) begin
        frame_color_q <= dec_color;
        white_flag_q  <= (cnt.white >= MIN_PIXELS);
        cnt_out_q     <= cnt;
      end
    end
  end

  assign bus.frame_color = frame_color_q;
  assign bus.white_flag  = white_flag_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.red_cnt     = cnt_out_q.red;
  assign bus.green_cnt   = cnt_out_q.green;
  assign bus.blue_cnt    = cnt_out_q.blue;
  assign bus.white_cnt   = cnt_out_q.white;

endmodule

// File: tb/tb_roi_color_accumulator.sv
// Scoreboard bench: a reduced raster scan feeds the accumulator, a behavioural model predicts each publish.
`timescale 1ns/1ps
module tb_roi_color_accumulator;
  import dice_color_pkg::*;

  localparam int M_RED    = 0;
  localparam int M_WHITE  = 1;
  localparam int M_GB     = 2;
  localparam int M_BORDER = 3;
  localparam int M_RST    = 4;
  localparam int M_1000   = 5;

  typedef struct {
    int     cyc;
    color_t color;
    int     white;
    int     r;
    int     g;
    int     b;
    int     w;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  roi_color_accumulator_if bus();

  roi_color_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          publishes = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        last_exp = '{cyc: 0, color: NONE, white: 0, r: 0, g: 0, b: 0, w: 0};
  logic        fv_prev = 1'b0;
  int          mc[5];
  logic [15:0] pend = 16'h0000;
  logic        prev_de = 1'b0;
  int          prev_x = 0;
  int          prev_y = 0;
  bit          discard = 1'b0;
  color_t      cmap[3] = '{RED, GREEN, BLUE};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Class index: 0 red, 1 green, 2 blue, 3 white, 4 other.
  function automatic int classify(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:12]);
    g = int'(p[10:7]);
    b = int'(p[4:1]);
    if (r >= 12 && g >= 12 && b >= 12) return 3;
    if (r >= 10 && g <= 6 && b <= 6) return 0;
    if (g >= 10 && r <= 6 && b <= 6) return 1;
    if (b >= 10 && r <= 6 && g <= 6) return 2;
    return 4;
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    return {r, 1'($urandom_range(0, 1)), g, 2'($urandom_range(0, 3)), b, 1'($urandom_range(0, 1))};
  endfunction

  function automatic logic [15:0] rnd(input int cls);
    case (cls)
      0:       return mk(4'($urandom_range(10, 15)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)));
      1:       return mk(4'($urandom_range(0, 6)), 4'($urandom_range(10, 15)), 4'($urandom_range(0, 6)));
      2:       return mk(4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)), 4'($urandom_range(10, 15)));
      3:       return mk(4'($urandom_range(12, 15)), 4'($urandom_range(12, 15)), 4'($urandom_range(12, 15)));
      default: return mk(4'($urandom_range(0, 15)), 4'($urandom_range(7, 9)), 4'($urandom_range(0, 15)));
    endcase
  endfunction

  function automatic logic [15:0] gen(input int mode, input int x, input int y);
    bit in;
    int k;
    in = (x >= 100 && x < 220 && y >= 60 && y < 180);
    k  = (y - 60) * 120 + (x - 100);
    case (mode)
      M_WHITE:  return 16'hFFFF;
      M_GB:     return ((x + y) % 2 == 0) ? rnd(1) : rnd(2);
      M_BORDER: return (!in || k < 998 || k == 14399) ? rnd(0) : 16'h0000;
      M_1000:   return (in && k < 1000) ? rnd(0) : ($urandom_range(0, 1) ? rnd(3) : rnd(4));
      default:  return 16'hF800;
    endcase
  endfunction

  // Model: counts ROI pixels by class; the final ROI pixel yields the expected publish.
  task automatic account(input logic de, input int x, input int y, input logic [15:0] p);
    exp_t e;
    int   best;
    if (de && x >= 100 && x < 220 && y >= 60 && y < 180) mc[classify(p)]++;
    if (de && x == 219 && y == 179 && !discard) begin
      best = 0;
      for (int i = 1; i < 3; i++) if (mc[i] > mc[best]) best = i;
      e.cyc   = cyc + 2;
      e.color = (mc[best] >= 1000) ? cmap[best] : NONE;
      e.white = (mc[3] >= 1000) ? 1 : 0;
      e.r = mc[0];
      e.g = mc[1];
      e.b = mc[2];
      e.w = mc[3];
      exp_q.push_back(e);
    end
  endtask

  // Frame-buffer data lags the coordinates by one cycle.
  task automatic drive(input logic de, input int x, input int y, input logic [15:0] rgb);
    @(negedge clk);
    bus.pixel_rgb = pend;
    account(prev_de, prev_x, prev_y, pend);
    bus.DE      = de;
    bus.x_pixel = 10'(x);
    bus.y_pixel = 10'(y);
    pend    = rgb;
    prev_de = de;
    prev_x  = x;
    prev_y  = y;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_color"}, bus.frame_color, NONE);
    check({tag, "_white_flag"}, bus.white_flag, 0);
    check({tag, "_valid"}, bus.frame_valid, 0);
    check({tag, "_red"}, bus.red_cnt, 0);
    check({tag, "_green"}, bus.green_cnt, 0);
    check({tag, "_blue"}, bus.blue_cnt, 0);
    check({tag, "_whitecnt"}, bus.white_cnt, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("mid_rst");
    reset = 1'b1;
  endtask

  task automatic run_frame(input int mode);
    int x_hi;
    for (int i = 0; i < 5; i++) mc[i] = 0;
    discard = (mode == M_RST);
    repeat (4) drive(1'b0, 0, 200, 16'h0000);
    for (int y = 59; y <= 180; y++) begin
      x_hi = (mode == M_RST && y < 120) ? 104 : 220;
      for (int x = 99; x <= x_hi; x++) begin
        if (mode == M_RST && y == 120 && x == 99) pulse_reset();
        drive(1'b1, x, y, gen(mode, x, y));
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.frame_valid) begin
      publishes++;
      check("valid_single", fv_prev, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("valid_cycle", cyc, mon_e.cyc);
        check("frame_color", bus.frame_color, mon_e.color);
        check("white_flag", bus.white_flag, mon_e.white);
        check("red_cnt", bus.red_cnt, mon_e.r);
        check("green_cnt", bus.green_cnt, mon_e.g);
        check("blue_cnt", bus.blue_cnt, mon_e.b);
        check("white_cnt", bus.white_cnt, mon_e.w);
        last_exp = mon_e;
      end
    end
    fv_prev = bus.frame_valid;
  end

  initial begin
    reset         = 1'b0;
    bus.DE        = 1'b0;
    bus.x_pixel   = '0;
    bus.y_pixel   = '0;
    bus.pixel_rgb = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    run_frame(M_RED);
    run_frame(M_WHITE);
    run_frame(M_GB);
    run_frame(M_BORDER);
    run_frame(M_RST);
    check_reset_vals("post_rst_hold");
    run_frame(M_1000);
    repeat (10) drive(1'b0, 0, 200, 16'h0000);

    check("queue_empty", exp_q.size(), 0);
    check("publish_count", publishes, 5);
    check("hold_color", bus.frame_color, last_exp.color);
    check("hold_red", bus.red_cnt, last_exp.r);
    check("hold_white", bus.white_cnt, last_exp.w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/roi_color_accumulator.md
# roi_color_accumulator

Per-frame colour statistics engine for the dice camera read path. Samples the RGB565 pixel stream from the dice frame buffer (as scanned by the VGA timing), classifies every pixel inside a fixed region of interest as red, green, blue, white or other, counts each class, and at frame end publishes the dominant colour, a white flag and the raw counts with a one-cycle valid strobe. It sits between the frame-buffer read port / VGA syncher and the colour stabiliser that feeds the game logic controller.

## Interface
- ROI_X_START, 10'd100, first ROI column (VGA coordinates, inclusive)
- ROI_X_END, 10'd220, ROI column bound (exclusive)
- ROI_Y_START, 10'd60, first ROI row (inclusive)
- ROI_Y_END, 10'd180, ROI row bound (exclusive)
- CNT_W, 15, counter width; counters saturate at all-ones
- TH_HI, 4'd10, minimum dominant-channel value for a colour pixel
- TH_LO, 4'd6, maximum other-channel value for a colour pixel
- WHITE_TH, 4'd12, minimum value of all three channels for a white pixel
- MIN_PIXELS, 15'd1000, minimum count for a colour or white decision
- clk  input  1  pixel clock (same domain as the VGA syncher and frame-buffer read port)
- reset  input  1  asynchronous, active-low reset
- DE  input  1  display enable from the VGA syncher
- x_pixel  input  10  current scan column
- y_pixel  input  10  current scan row
- pixel_rgb  input  16  RGB565 read data; valid one cycle after the matching x_pixel/y_pixel
- frame_color  output  2  dominant colour (package encoding)
- white_flag  output  1  white count reached threshold in the last frame
- frame_valid  output  1  one-cycle strobe: new results published
- red_cnt, green_cnt, blue_cnt, white_cnt  output  CNT_W each  last published class counts

## Operation
- Alignment: DE, x_pixel and y_pixel are registered once, so the sample stage uses the delayed coordinates with the current pixel_rgb. This compensates the one-cycle frame-buffer read latency.
- Channels: r = pixel_rgb[15:12], g = [10:7], b = [4:1].
- Classification (priority order):
  - white: r, g, b all ≥ WHITE_TH
  - red: r ≥ TH_HI, g ≤ TH_LO, b ≤ TH_LO
  - green, blue: same rule with the roles rotated
  - other: not counted
- A pixel counts only when delayed DE = 1 and the delayed coordinates lie inside the ROI.
- FSM states:
  - WAIT_FRAME: counters held. When delayed y_pixel < ROI_Y_START, clear all counters and go to ACCUM.
  - ACCUM: increment the matching counter (saturating). When the sample at (ROI_X_END-1, ROI_Y_END-1) is counted, go to DECIDE.
  - DECIDE: compute the decision (below) and go to PUBLISH.
  - PUBLISH: register outputs, assert frame_valid, go to WAIT_FRAME.
- Decision:
  - max = largest of red/green/blue counts; ties resolve red > green > blue.
  - frame_color = winning colour if max ≥ MIN_PIXELS, else NONE.
  - white_flag = white_cnt ≥ MIN_PIXELS.
  - Counts are copied unchanged to the output registers.
- If the ROI-final pixel arrives with DE = 0 (misconfigured ROI), the FSM never leaves ACCUM. Parameters must keep the ROI inside the active area.

## Timing
- Reset values: frame_color = NONE (2'd3); white_flag, frame_valid = 0; all counts = 0; FSM = WAIT_FRAME; delay registers = 0.
- Let cycle N be the cycle in which pixel_rgb of the final ROI pixel is sampled:
  - counters update at the end of N
  - DECIDE occupies N+1
  - outputs change and frame_valid = 1 during N+2, for exactly one cycle
- Outputs hold their values until the next PUBLISH.
- Reset mid-frame: the partial frame is discarded. The first frame_valid follows the first complete ROI scan after reset release.
- Saturation: a counter at all-ones stays there. Not reachable with the default ROI (14400 < 32767).
- No backpressure: the consumer must accept frame_valid whenever it fires, once per frame (about 420k cycles apart).

## Structure
- Shared package dice_color_pkg:
  - color_t enum: RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2, NONE = 2'd3
  - FSM state enum
  - pixel-class enum
- The colour stabiliser and the game logic controller import the same package.
- One sub-module: pixel_classifier, a combinational RGB565-to-class map parameterised by TH_HI, TH_LO and WHITE_TH. It is reused by the display overlay.

## Test plan
- Full frame of 16'hF800 (pure red) → red_cnt = 14400, others 0, frame_color = RED, white_flag = 0, frame_valid one cycle at N+2.
- Full frame of 16'hFFFF → white_cnt = 14400, frame_color = NONE, white_flag = 1.
- ROI with 7200 green and 7200 blue pixels → tie resolves to GREEN; counts exact.
- Only 999 red pixels, remainder black → frame_color = NONE, red_cnt = 999; at 1000 pixels → RED.
- Red pixels placed only outside the ROI (x = 99 and x = 220, y = 59 and y = 180) → all counts 0. One pixel at (100,60) and one at (219,179) → red_cnt = 2. This checks the one-cycle alignment.
- Assert reset (drive low) at row 120 of the ROI, release → no frame_valid for that frame; the next full frame publishes correct counts, and outputs read reset values until then.
